// File: rtl/hack_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hack_mem_pkg
// Description : Shared definitions for the HACK dual-port RAM: read-during-
//               write mode selectors, clear-sequencer state encoding and the
//               read-latency helper.
// Revision    : 1.0 - initial release
// ============================================================================
package hack_mem_pkg;

    // Port A same-address read/write behaviour
    localparam int RD_FIRST = 0;    // return the word stored before the write
    localparam int WR_FIRST = 1;    // return the word being written

    // Clear sequencer states
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    // Read latency in clocks: one for the array read, plus the optional
    // output register stage.
    function automatic int unsigned rd_latency(input int unsigned out_reg);
        return 32'd1 + out_reg;
    endfunction

endpackage : hack_mem_pkg
`default_nettype wire

// File: rtl/hack_ram_clear_seq.sv
`default_nettype none
// ============================================================================
// Module      : hack_ram_clear_seq
// Description : Clear-on-reset sequencer. After reset it walks every address
//               of the array once, requesting a zero write per clock, and
//               flags busy until the last word has been written.
// Ports       : clk      - clock
//               reset    - synchronous active-high reset (restarts the walk)
//               busy     - clear in progress
//               clr_we   - write-zero strobe for the array
//               clr_addr - address being cleared
// Revision    : 1.0 - initial release
// ============================================================================
module hack_ram_clear_seq
    import hack_mem_pkg::*;
#(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] C_LAST_ADDR = '1;

    clr_state_e        r_state_q;
    clr_state_e        w_state_d;
    logic [ADDR_W-1:0] r_clr_addr_q;
    logic [ADDR_W-1:0] w_clr_addr_d;
    logic              w_clr_we;

    // State register; reset from any state restarts the walk at address 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q    <= ST_CLEAR;
            r_clr_addr_q <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_clr_addr_q <= w_clr_addr_d;
        end
    end

    always_comb begin
        w_state_d    = r_state_q;
        w_clr_addr_d = r_clr_addr_q;
        w_clr_we     = 1'b0;
        case (r_state_q)
            ST_IDLE: begin
                w_state_d = ST_IDLE;
            end
            ST_CLEAR: begin
                w_clr_we = 1'b1;
                // The top word is written and the walk ends; no roll-over.
                if (r_clr_addr_q == C_LAST_ADDR) begin
                    w_state_d    = ST_IDLE;
                    w_clr_addr_d = '0;
                end else begin
                    w_clr_addr_d = r_clr_addr_q + ADDR_W'(1);
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // Holding reset keeps the sequencer parked at address 0 without touching
    // the array, so the write strobe is suppressed while reset is high.
    assign clr_we   = w_clr_we && !reset;
    assign clr_addr = r_clr_addr_q;
    assign busy     = (r_state_q == ST_CLEAR);

endmodule : hack_ram_clear_seq
`default_nettype wire

// File: rtl/hack_ram_dp.sv
`default_nettype none
// ============================================================================
// Module      : hack_ram_dp
// Description : Dual-port synchronous RAM for the HACK memory system.
//               Port A read/write (CPU data), port B read-only (screen /
//               debug). Selectable read-during-write on port A, optional
//               output register, optional hardware clear after reset.
// Ports       : clk, reset           - clock, synchronous active-high reset
//               a_data/a_load/a_addr - port A write data, write enable, address
//               a_out                - port A read data (LAT clocks)
//               b_rd/b_addr          - port B read request and address
//               b_out/b_valid        - port B read data and its valid flag
//               busy                 - clear sequence running, ports ignored
// Revision    : 1.0 - initial release
// ============================================================================
module hack_ram_dp
    import hack_mem_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 15,
    parameter int RD_MODE        = 0,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] a_data,
    input  logic              a_load,
    input  logic [ADDR_W-1:0] a_addr,
    output logic [DATA_W-1:0] a_out,
    input  logic              b_rd,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [DATA_W-1:0] b_out,
    output logic              b_valid,
    output logic              busy
);

    localparam int          DEPTH = 2 ** ADDR_W;
    localparam int unsigned LAT   = rd_latency($unsigned(OUT_REG));

    logic [DATA_W-1:0] mem [DEPTH];

    logic              w_busy;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;

    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;

    logic [DATA_W-1:0] r_a_rd_q;
    logic [DATA_W-1:0] r_b_rd_q;
    logic              r_b_vld_q;

    // ------------------------------------------------------------------
    // Clear sequencer (present only when clear-on-reset is enabled)
    // ------------------------------------------------------------------
    generate
        if (CLEAR_ON_RESET != 0) begin : g_clear
            hack_ram_clear_seq #(
                .ADDR_W (ADDR_W)
            ) u_clear_seq (
                .clk      (clk),
                .reset    (reset),
                .busy     (w_busy),
                .clr_we   (w_clr_we),
                .clr_addr (w_clr_addr)
            );
        end else begin : g_no_clear
            assign w_busy     = 1'b0;
            assign w_clr_we   = 1'b0;
            assign w_clr_addr = '0;
        end
    endgenerate

    assign busy = w_busy;

    // ------------------------------------------------------------------
    // Single write path: the clear sequencer owns it while busy.
    // ------------------------------------------------------------------
    always_comb begin
        w_we    = 1'b0;
        w_waddr = a_addr;
        w_wdata = a_data;
        if (reset) begin
            w_we = 1'b0;
        end else if (w_busy) begin
            w_we    = w_clr_we;
            w_waddr = w_clr_addr;
            w_wdata = '0;
        end else begin
            w_we = a_load;
        end
    end

    // Array write. No reset here so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_we) begin
            mem[w_waddr] <= w_wdata;
        end
    end

    // ------------------------------------------------------------------
    // First read stage. Non-blocking array reads see the pre-write word,
    // which gives read-first on A and the old-data collision result on B.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset || w_busy) begin
            r_a_rd_q  <= '0;
            r_b_rd_q  <= '0;
            r_b_vld_q <= 1'b0;
        end else begin
            if ((RD_MODE == WR_FIRST) && a_load) begin
                r_a_rd_q <= a_data;
            end else begin
                r_a_rd_q <= mem[a_addr];
            end
            r_b_vld_q <= b_rd;
            if (b_rd) begin
                r_b_rd_q <= mem[b_addr];
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional output register stage
    // ------------------------------------------------------------------
    generate
        if (LAT > 1) begin : g_out_reg
            logic [DATA_W-1:0] r_a_out_q;
            logic [DATA_W-1:0] r_b_out_q;
            logic              r_b_vld2_q;

            always_ff @(posedge clk) begin
                if (reset || w_busy) begin
                    r_a_out_q  <= '0;
                    r_b_out_q  <= '0;
                    r_b_vld2_q <= 1'b0;
                end else begin
                    r_a_out_q  <= r_a_rd_q;
                    r_b_vld2_q <= r_b_vld_q;
                    // b_out only moves when a valid word reaches it
                    if (r_b_vld_q) begin
                        r_b_out_q <= r_b_rd_q;
                    end
                end
            end

            assign a_out   = r_a_out_q;
            assign b_out   = r_b_out_q;
            assign b_valid = r_b_vld2_q;
        end else begin : g_no_out_reg
            assign a_out   = r_a_rd_q;
            assign b_out   = r_b_rd_q;
            assign b_valid = r_b_vld_q;
        end
    endgenerate

endmodule : hack_ram_dp
`default_nettype wire

// File: tb/tb_hack_ram_dp.sv
`default_nettype none
// ============================================================================
// Module      : tb_hack_ram_dp
// Description : Self-checking bench for hack_ram_dp. Three instances share
//               the inputs: dut0 read-first/latency 1, dut1 write-first/
//               latency 2, dut2 latency 1 without clear-on-reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hack_ram_dp;

    logic        clk;
    logic        reset;
    logic [15:0] a_data;
    logic        a_load;
    logic [3:0]  a_addr;
    logic        b_rd;
    logic [3:0]  b_addr;

    logic [15:0] a_out0, b_out0, a_out1, b_out1, a_out2, b_out2;
    logic        b_valid0, b_valid1, b_valid2;
    logic        busy0, busy1, busy2;

    int n_chk  = 0;
    int n_fail = 0;

    hack_ram_dp #(.DATA_W(16), .ADDR_W(4), .RD_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(1)) dut0 (
        .clk(clk), .reset(reset), .a_data(a_data), .a_load(a_load), .a_addr(a_addr),
        .a_out(a_out0), .b_rd(b_rd), .b_addr(b_addr), .b_out(b_out0), .b_valid(b_valid0),
        .busy(busy0));

    hack_ram_dp #(.DATA_W(16), .ADDR_W(4), .RD_MODE(1), .OUT_REG(1), .CLEAR_ON_RESET(1)) dut1 (
        .clk(clk), .reset(reset), .a_data(a_data), .a_load(a_load), .a_addr(a_addr),
        .a_out(a_out1), .b_rd(b_rd), .b_addr(b_addr), .b_out(b_out1), .b_valid(b_valid1),
        .busy(busy1));

    hack_ram_dp #(.DATA_W(16), .ADDR_W(4), .RD_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(0)) dut2 (
        .clk(clk), .reset(reset), .a_data(a_data), .a_load(a_load), .a_addr(a_addr),
        .a_out(a_out2), .b_rd(b_rd), .b_addr(b_addr), .b_out(b_out2), .b_valid(b_valid2),
        .busy(busy2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        a_load;
        logic [3:0]  a_addr;
        logic [15:0] a_data;
        logic        b_rd;
        logic [3:0]  b_addr;
        logic [15:0] e0_a;   // read-first a_out
        logic [15:0] e_b;    // b_out
        logic        e_bv;   // b_valid
        logic [15:0] e1_a;   // write-first a_out
    } vec_t;

    vec_t vecs [9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic preload(input logic [15:0] d);
        for (int i = 0; i < 16; i++) begin
            a_load = 1'b1;
            a_addr = 4'(i);
            a_data = d;
            step();
        end
        a_load = 1'b0;
    endtask

    // Pulse reset for one clock and count busy cycles on each clearing DUT.
    // With lock set, port traffic is driven throughout the clear.
    task automatic clear_and_count(input bit lock, input string tag);
        int c0;
        int c1;
        bit first;
        c0    = 0;
        c1    = 0;
        first = 1'b1;
        reset  = 1'b1;
        a_load = 1'b0;
        b_rd   = 1'b0;
        step();
        while ((busy0 || busy1) && c0 < 40 && c1 < 40) begin
            if (busy0) c0++;
            if (busy1) c1++;
            chk($sformatf("%s dut0 a_out busy", tag), a_out0, 16'h0000);
            chk($sformatf("%s dut0 b_out busy", tag), b_out0, 16'h0000);
            chk_bit($sformatf("%s dut0 b_valid busy", tag), b_valid0, 1'b0);
            chk($sformatf("%s dut1 a_out busy", tag), a_out1, 16'h0000);
            chk_bit($sformatf("%s dut1 b_valid busy", tag), b_valid1, 1'b0);
            chk_bit($sformatf("%s dut2 busy", tag), busy2, 1'b0);
            if (first) begin
                chk($sformatf("%s dut2 a_out reset", tag), a_out2, 16'h0000);
                chk($sformatf("%s dut2 b_out reset", tag), b_out2, 16'h0000);
                chk_bit($sformatf("%s dut2 b_valid reset", tag), b_valid2, 1'b0);
                first = 1'b0;
            end
            reset = 1'b0;
            if (lock) begin
                a_load = 1'b1;
                a_addr = 4'd2;
                a_data = 16'hDEAD;
                b_rd   = 1'b1;
                b_addr = 4'd2;
            end
            step();
        end
        reset  = 1'b0;
        a_load = 1'b0;
        b_rd   = 1'b0;
        chk($sformatf("%s dut0 busy cycles", tag), 16'(c0), 16'd16);
        chk($sformatf("%s dut1 busy cycles", tag), 16'(c1), 16'd16);
        chk_bit($sformatf("%s dut0 busy after", tag), busy0, 1'b0);
    endtask

    // Read every address on both ports of all instances.
    task automatic read_all(input logic [15:0] exp01, input logic [15:0] exp2,
                            input bit dead2, input string tag);
        logic [15:0] e2;
        for (int i = 0; i < 16; i++) begin
            a_addr = 4'(i);
            b_addr = 4'(i);
            b_rd   = 1'b1;
            step();
            e2 = (dead2 && i == 2) ? 16'hDEAD : exp2;
            chk($sformatf("%s dut0 a_out[%0d]", tag, i), a_out0, exp01);
            chk($sformatf("%s dut0 b_out[%0d]", tag, i), b_out0, exp01);
            chk_bit($sformatf("%s dut0 b_valid[%0d]", tag, i), b_valid0, 1'b1);
            chk($sformatf("%s dut2 a_out[%0d]", tag, i), a_out2, e2);
            step();
            chk($sformatf("%s dut1 a_out[%0d]", tag, i), a_out1, exp01);
            chk($sformatf("%s dut1 b_out[%0d]", tag, i), b_out1, exp01);
            chk_bit($sformatf("%s dut1 b_valid[%0d]", tag, i), b_valid1, 1'b1);
        end
        b_rd = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        a_data = 16'h0000;
        a_load = 1'b0;
        a_addr = 4'd0;
        b_rd   = 1'b0;
        b_addr = 4'd0;

        //                a_load  addr   data      b_rd  b_addr  e0_a      e_b       e_bv  e1_a
        vecs[0] = '{1'b1, 4'd5, 16'h1234, 1'b0, 4'd0, 16'h0000, 16'h0000, 1'b0, 16'h1234};
        vecs[1] = '{1'b0, 4'd5, 16'h0000, 1'b1, 4'd5, 16'h1234, 16'h1234, 1'b1, 16'h1234};
        vecs[2] = '{1'b1, 4'd3, 16'hAAAA, 1'b0, 4'd0, 16'h0000, 16'h1234, 1'b0, 16'hAAAA};
        vecs[3] = '{1'b1, 4'd3, 16'h5555, 1'b0, 4'd0, 16'hAAAA, 16'h1234, 1'b0, 16'h5555};
        vecs[4] = '{1'b0, 4'd3, 16'h0000, 1'b1, 4'd3, 16'h5555, 16'h5555, 1'b1, 16'h5555};
        vecs[5] = '{1'b1, 4'd9, 16'h0F0F, 1'b0, 4'd0, 16'h0000, 16'h5555, 1'b0, 16'h0F0F};
        vecs[6] = '{1'b1, 4'd9, 16'hBEEF, 1'b1, 4'd9, 16'h0F0F, 16'h0F0F, 1'b1, 16'hBEEF};
        vecs[7] = '{1'b0, 4'd9, 16'h0000, 1'b1, 4'd9, 16'hBEEF, 16'hBEEF, 1'b1, 16'hBEEF};
        vecs[8] = '{1'b0, 4'd5, 16'h0000, 1'b0, 4'd0, 16'h1234, 16'hBEEF, 1'b0, 16'h1234};

        // Power-up clear
        clear_and_count(1'b0, "init");

        // Reset clear over a fully-set array
        preload(16'hFFFF);
        clear_and_count(1'b0, "clr");
        read_all(16'h0000, 16'hFFFF, 1'b0, "clr");

        // Reset reasserted part-way through the clear
        preload(16'hFFFF);
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (6) step();
        chk_bit("midclr dut0 busy before restart", busy0, 1'b1);
        clear_and_count(1'b0, "midclr");
        read_all(16'h0000, 16'hFFFF, 1'b0, "midclr");

        // Port traffic during clear is ignored
        clear_and_count(1'b1, "lock");
        read_all(16'h0000, 16'hFFFF, 1'b1, "lock");

        // Latency, read-during-write and cross-port collision vectors
        for (int i = 0; i < 9; i++) begin
            a_load = vecs[i].a_load;
            a_addr = vecs[i].a_addr;
            a_data = vecs[i].a_data;
            b_rd   = vecs[i].b_rd;
            b_addr = vecs[i].b_addr;
            step();
            chk($sformatf("vec%0d dut0 a_out", i), a_out0, vecs[i].e0_a);
            chk($sformatf("vec%0d dut0 b_out", i), b_out0, vecs[i].e_b);
            chk_bit($sformatf("vec%0d dut0 b_valid", i), b_valid0, vecs[i].e_bv);
            if (i > 0) begin
                chk($sformatf("vec%0d dut1 a_out", i - 1), a_out1, vecs[i-1].e1_a);
                chk($sformatf("vec%0d dut1 b_out", i - 1), b_out1, vecs[i-1].e_b);
                chk_bit($sformatf("vec%0d dut1 b_valid", i - 1), b_valid1, vecs[i-1].e_bv);
            end
        end
        a_load = 1'b0;
        b_rd   = 1'b0;
        step();
        chk("vec8 dut1 a_out", a_out1, vecs[8].e1_a);
        chk("vec8 dut1 b_out", b_out1, vecs[8].e_b);
        chk_bit("vec8 dut1 b_valid", b_valid1, vecs[8].e_bv);

        // Exact latency: address change from @3 to @5 on both ports
        a_addr = 4'd3;
        step();
        step();
        chk("lat dut0 a_out @3", a_out0, 16'h5555);
        chk("lat dut1 a_out @3", a_out1, 16'h5555);
        a_addr = 4'd5;
        b_rd   = 1'b1;
        b_addr = 4'd5;
        step();
        b_rd = 1'b0;
        chk("lat1 dut0 a_out", a_out0, 16'h1234);
        chk_bit("lat1 dut0 b_valid", b_valid0, 1'b1);
        chk("lat1 dut0 b_out", b_out0, 16'h1234);
        chk("lat1 dut1 a_out", a_out1, 16'h5555);
        chk_bit("lat1 dut1 b_valid", b_valid1, 1'b0);
        chk("lat1 dut1 b_out held", b_out1, 16'hBEEF);
        step();
        chk("lat2 dut1 a_out", a_out1, 16'h1234);
        chk_bit("lat2 dut1 b_valid", b_valid1, 1'b1);
        chk("lat2 dut1 b_out", b_out1, 16'h1234);
        chk_bit("lat2 dut0 b_valid", b_valid0, 1'b0);
        chk("lat2 dut0 b_out held", b_out0, 16'h1234);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_hack_ram_dp
`default_nettype wire
